// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage
// RV32I instruction decode with a single registered output stage.
// Register-file addresses come straight from the incoming instruction.
// The read data is sampled together with the decoded control fields on accept.
// A valid/ready pair on each side lets the stage sustain one instruction per cycle.
module riscv_decode_stage #(
  parameter int WORD_LENGTH = 32,
  parameter int EXEC_FUN    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [WORD_LENGTH-1:0] in_pc,
  input  logic                   flush,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [WORD_LENGTH-1:0] rs1_data,
  input  logic [WORD_LENGTH-1:0] rs2_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXEC_FUN-1:0]    exec_fun,
  output logic [WORD_LENGTH-1:0] data1,
  output logic [WORD_LENGTH-1:0] data2,
  output logic [WORD_LENGTH-1:0] rs2_val,
  output logic [4:0]             rd,
  output logic                   wb_en,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [2:0]             br_type,
  output logic [WORD_LENGTH-1:0] br_target,
  output logic                   illegal
);

  // ALU operation codes
  localparam logic [EXEC_FUN-1:0] ALU_ADD  = 4'd0;
  localparam logic [EXEC_FUN-1:0] ALU_SUB  = 4'd1;
  localparam logic [EXEC_FUN-1:0] ALU_SLL  = 4'd2;
  localparam logic [EXEC_FUN-1:0] ALU_SLT  = 4'd3;
  localparam logic [EXEC_FUN-1:0] ALU_SLTU = 4'd4;
  localparam logic [EXEC_FUN-1:0] ALU_XOR  = 4'd5;
  localparam logic [EXEC_FUN-1:0] ALU_SRL  = 4'd6;
  localparam logic [EXEC_FUN-1:0] ALU_SRA  = 4'd7;
  localparam logic [EXEC_FUN-1:0] ALU_OR   = 4'd8;
  localparam logic [EXEC_FUN-1:0] ALU_AND  = 4'd9;

  // Control-transfer kinds
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_JAL  = 3'd3;
  localparam logic [2:0] BR_JALR = 3'd4;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [WORD_LENGTH-1:0] WORD_ZERO = {WORD_LENGTH{1'b0}};
  localparam logic [WORD_LENGTH-1:0] WORD_FOUR = {{(WORD_LENGTH-3){1'b0}}, 3'b100};
  localparam logic [WORD_LENGTH-1:0] LSB_CLEAR = {{(WORD_LENGTH-1){1'b1}}, 1'b0};

  // funct3 (plus the alternate bit instr[30]) to ALU operation
  function automatic logic [EXEC_FUN-1:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [EXEC_FUN-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Register-register: funct7 is zero, or 0100000 only for SUB/SRA
  function automatic logic r_legal(input logic [2:0] f3, input logic [6:0] f7);
    logic ok;
    case (f7)
      7'b0000000: ok = 1'b1;
      7'b0100000: ok = (f3 == 3'b000) || (f3 == 3'b101);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Register-immediate: only the shift forms constrain the upper bits
  function automatic logic i_legal(input logic [2:0] f3, input logic [6:0] f7);
    logic ok;
    case (f3)
      3'b001:  ok = (f7 == 7'b0000000);
      3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Loads: byte, half, word and their unsigned variants
  function automatic logic load_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Stores: byte, half, word
  function automatic logic store_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Instruction fields and immediates
  logic [6:0]             opcode_s;
  logic [2:0]             funct3_s;
  logic [6:0]             funct7_s;
  logic [4:0]             rd_field_s;
  logic [WORD_LENGTH-1:0] rs1_val_s;
  logic [WORD_LENGTH-1:0] rs2_val_s;
  logic [WORD_LENGTH-1:0] imm_i_s;
  logic [WORD_LENGTH-1:0] imm_s_s;
  logic [WORD_LENGTH-1:0] imm_b_s;
  logic [WORD_LENGTH-1:0] imm_j_s;
  logic [WORD_LENGTH-1:0] imm_u_s;
  logic [WORD_LENGTH-1:0] shamt_s;
  logic [WORD_LENGTH-1:0] jalr_sum_s;
  logic                   accept_s;

  // Decoded (pre-register) fields
  logic [EXEC_FUN-1:0]    dec_fun_s;
  logic [WORD_LENGTH-1:0] dec_data1_s;
  logic [WORD_LENGTH-1:0] dec_data2_s;
  logic [WORD_LENGTH-1:0] dec_target_s;
  logic [4:0]             dec_rd_s;
  logic                   dec_writes_s;
  logic                   dec_ren_s;
  logic                   dec_wen_s;
  logic [2:0]             dec_br_s;
  logic                   dec_legal_s;

  // Output stage registers
  logic                   out_valid_r;
  logic [EXEC_FUN-1:0]    exec_fun_r;
  logic [WORD_LENGTH-1:0] data1_r;
  logic [WORD_LENGTH-1:0] data2_r;
  logic [WORD_LENGTH-1:0] rs2_val_r;
  logic [4:0]             rd_r;
  logic                   wb_en_r;
  logic                   mem_ren_r;
  logic                   mem_wen_r;
  logic [2:0]             br_type_r;
  logic [WORD_LENGTH-1:0] br_target_r;
  logic                   illegal_r;

  assign opcode_s   = in_instr[6:0];
  assign funct3_s   = in_instr[14:12];
  assign funct7_s   = in_instr[31:25];
  assign rd_field_s = in_instr[11:7];
  assign rs1_addr   = in_instr[19:15];
  assign rs2_addr   = in_instr[24:20];

  // x0 always reads as zero whatever the register file returns
  assign rs1_val_s = (rs1_addr == 5'd0) ? WORD_ZERO : rs1_data;
  assign rs2_val_s = (rs2_addr == 5'd0) ? WORD_ZERO : rs2_data;

  assign imm_i_s = {{(WORD_LENGTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s_s = {{(WORD_LENGTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b_s = {{(WORD_LENGTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j_s = {{(WORD_LENGTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u_s = {{(WORD_LENGTH-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign shamt_s = {{(WORD_LENGTH-5){1'b0}}, in_instr[24:20]};

  // JALR target ignores bit 0 of the computed address
  assign jalr_sum_s = rs1_val_s + imm_i_s;

  // A stalled output blocks input; an empty or draining one lets it through
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Opcode decode into ALU operation, operands, strobes and control transfer
  always_comb begin
    dec_fun_s    = ALU_ADD;
    dec_data1_s  = WORD_ZERO;
    dec_data2_s  = WORD_ZERO;
    dec_target_s = WORD_ZERO;
    dec_rd_s     = 5'd0;
    dec_writes_s = 1'b0;
    dec_ren_s    = 1'b0;
    dec_wen_s    = 1'b0;
    dec_br_s     = BR_NONE;
    dec_legal_s  = 1'b1;
    case (opcode_s)
      OP_R: begin
        dec_legal_s  = r_legal(funct3_s, funct7_s);
        dec_fun_s    = alu_op(funct3_s, in_instr[30]);
        dec_data1_s  = rs1_val_s;
        dec_data2_s  = rs2_val_s;
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
      end
      OP_I: begin
        dec_legal_s  = i_legal(funct3_s, funct7_s);
        dec_fun_s    = alu_op(funct3_s, (funct3_s == 3'b101) && in_instr[30]);
        dec_data1_s  = rs1_val_s;
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          dec_data2_s = shamt_s;
        end else begin
          dec_data2_s = imm_i_s;
        end
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
      end
      OP_LUI: begin
        dec_data2_s  = imm_u_s;
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
      end
      OP_AUIPC: begin
        dec_data1_s  = in_pc;
        dec_data2_s  = imm_u_s;
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
      end
      OP_LOAD: begin
        dec_legal_s  = load_legal(funct3_s);
        dec_data1_s  = rs1_val_s;
        dec_data2_s  = imm_i_s;
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
        dec_ren_s    = 1'b1;
      end
      OP_STORE: begin
        dec_legal_s = store_legal(funct3_s);
        dec_data1_s = rs1_val_s;
        dec_data2_s = imm_s_s;
        dec_wen_s   = 1'b1;
      end
      OP_BRANCH: begin
        dec_data1_s  = rs1_val_s;
        dec_data2_s  = rs2_val_s;
        dec_target_s = in_pc + imm_b_s;
        case (funct3_s)
          3'b000:  dec_br_s = BR_BEQ;
          3'b001:  dec_br_s = BR_BNE;
          default: dec_legal_s = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec_data1_s  = in_pc;
        dec_data2_s  = WORD_FOUR;
        dec_target_s = in_pc + imm_j_s;
        dec_br_s     = BR_JAL;
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
      end
      OP_JALR: begin
        dec_legal_s  = (funct3_s == 3'b000);
        dec_data1_s  = in_pc;
        dec_data2_s  = WORD_FOUR;
        dec_target_s = jalr_sum_s & LSB_CLEAR;
        dec_br_s     = BR_JALR;
        dec_rd_s     = rd_field_s;
        dec_writes_s = 1'b1;
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Output stage: flush wins, then capture on accept, then drain when taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      exec_fun_r  <= ALU_ADD;
      data1_r     <= WORD_ZERO;
      data2_r     <= WORD_ZERO;
      rs2_val_r   <= WORD_ZERO;
      rd_r        <= 5'd0;
      wb_en_r     <= 1'b0;
      mem_ren_r   <= 1'b0;
      mem_wen_r   <= 1'b0;
      br_type_r   <= BR_NONE;
      br_target_r <= WORD_ZERO;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      rs2_val_r   <= rs2_val_s;
      illegal_r   <= !dec_legal_s;
      if (dec_legal_s) begin
        exec_fun_r  <= dec_fun_s;
        data1_r     <= dec_data1_s;
        data2_r     <= dec_data2_s;
        rd_r        <= dec_rd_s;
        wb_en_r     <= dec_writes_s && (dec_rd_s != 5'd0);
        mem_ren_r   <= dec_ren_s;
        mem_wen_r   <= dec_wen_s;
        br_type_r   <= dec_br_s;
        br_target_r <= dec_target_s;
      end else begin
        // Unsupported encodings travel on with every side effect suppressed
        exec_fun_r  <= ALU_ADD;
        data1_r     <= WORD_ZERO;
        data2_r     <= WORD_ZERO;
        rd_r        <= 5'd0;
        wb_en_r     <= 1'b0;
        mem_ren_r   <= 1'b0;
        mem_wen_r   <= 1'b0;
        br_type_r   <= BR_NONE;
        br_target_r <= WORD_ZERO;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign exec_fun  = exec_fun_r;
  assign data1     = data1_r;
  assign data2     = data2_r;
  assign rs2_val   = rs2_val_r;
  assign rd        = rd_r;
  assign wb_en     = wb_en_r;
  assign mem_ren   = mem_ren_r;
  assign mem_wen   = mem_wen_r;
  assign br_type   = br_type_r;
  assign br_target = br_target_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Testbench for riscv_decode_stage: directed vectors plus a randomized
// stream scored against an instruction-level reference model.
module tb_riscv_decode_stage;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SLL  = 4'd2;
  localparam logic [3:0] F_SLT  = 4'd3;
  localparam logic [3:0] F_SLTU = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_SRL  = 4'd6;
  localparam logic [3:0] F_SRA  = 4'd7;
  localparam logic [3:0] F_OR   = 4'd8;
  localparam logic [3:0] F_AND  = 4'd9;

  typedef struct packed {
    logic [3:0]  fun;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] r2v;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        wr;
    logic        wb;
    logic        ren;
    logic        wen;
    logic        ill;
    logic [2:0]  br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        in_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        out_valid;
  logic [3:0]  exec_fun;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic        wb_en;
  logic        mem_ren;
  logic        mem_wen;
  logic [2:0]  br_type;
  logic [31:0] br_target;
  logic        illegal;

  int n_checks = 0;
  int n_pass = 0;

  riscv_decode_stage #(.WORD_LENGTH(32), .EXEC_FUN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .exec_fun(exec_fun),
    .data1(data1), .data2(data2), .rs2_val(rs2_val), .rd(rd), .wb_en(wb_en),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .br_type(br_type),
    .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? F_SUB : F_ADD;
      3'd1: return F_SLL;
      3'd2: return F_SLT;
      3'd3: return F_SLTU;
      3'd4: return F_XOR;
      3'd5: return alt ? F_SRA : F_SRL;
      3'd6: return F_OR;
      default: return F_AND;
    endcase
  endfunction

  // Reference: what the instruction means, per field, as plain arithmetic
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] x, y, imm_i, imm_s, imm_b, imm_j;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, sh;
    f3 = w[14:12];
    f7 = w[31:25];
    x = (w[19:15] == 5'd0) ? 32'd0 : a;
    y = (w[24:20] == 5'd0) ? 32'd0 : b;
    imm_i = 32'($signed(w[31:20]));
    imm_s = 32'($signed({w[31:25], w[11:7]}));
    imm_b = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    imm_j = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    e = '0;
    e.r2v = y;
    e.rd = w[11:7];
    ok = 1'b1;
    case (w[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.fun = alu_code(f3, f7 == 7'h20); e.d1 = x; e.d2 = y; e.wr = 1'b1;
      end
      7'h13: begin
        sh = (f3 == 3'd1) || (f3 == 3'd5);
        ok = !sh || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        e.fun = alu_code(f3, sh && f7 == 7'h20); e.d1 = x;
        e.d2 = sh ? {27'd0, w[24:20]} : imm_i; e.wr = 1'b1;
      end
      7'h37: begin e.d1 = 32'd0; e.d2 = {w[31:12], 12'd0}; e.wr = 1'b1; end
      7'h17: begin e.d1 = pc; e.d2 = {w[31:12], 12'd0}; e.wr = 1'b1; end
      7'h03: begin
        ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        e.d1 = x; e.d2 = imm_i; e.ren = 1'b1; e.wr = 1'b1;
      end
      7'h23: begin ok = (f3 <= 3'd2); e.d1 = x; e.d2 = imm_s; e.wen = 1'b1; end
      7'h63: begin
        ok = (f3 <= 3'd1); e.d1 = x; e.d2 = y;
        e.br = (f3 == 3'd0) ? 3'd1 : 3'd2; e.tgt = pc + imm_b;
      end
      7'h6F: begin e.d1 = pc; e.d2 = 32'd4; e.wr = 1'b1; e.br = 3'd3; e.tgt = pc + imm_j; end
      7'h67: begin
        ok = (f3 == 3'd0); e.d1 = pc; e.d2 = 32'd4; e.wr = 1'b1; e.br = 3'd4;
        e.tgt = (x + imm_i) & 32'hFFFF_FFFE;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
      e.r2v = y;
    end
    e.wb = e.wr && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      default: w[6:0] = w[6:0];
    endcase
    k = $urandom_range(0, 3);
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      if (k == 1) w[31:25] = 7'h20;
      else if (k != 3) w[31:25] = 7'h00;
    end
    if (w[6:0] == 7'h63 && k != 0) w[14:12] = {2'b00, w[12]};
    if (w[6:0] == 7'h67 && k != 0) w[14:12] = 3'd0;
    if ($urandom_range(0, 4) == 0) w[19:15] = 5'd0;
    if ($urandom_range(0, 4) == 0) w[24:20] = 5'd0;
    if ($urandom_range(0, 6) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic test_reset();
    in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h100; out_ready = 1'b1; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, wb_en, mem_ren, mem_wen, br_type, illegal, exec_fun} !== {6'b000000, 3'd0, F_ADD})
      $display("FAIL reset_ctrl: got %h expected %h",
               {out_valid, wb_en, mem_ren, mem_wen, br_type, illegal, exec_fun}, {6'b000000, 3'd0, F_ADD});
    else n_pass++;
    n_checks++;
    if ({data1, data2, rs2_val, br_target, rd} !== {128'd0, 5'd0})
      $display("FAIL reset_data: got %h %h %h %h %h expected all zero", data1, data2, rs2_val, br_target, rd);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_hold: got out_valid=%b expected 0", out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, rd, data2, wb_en} !== {1'b1, 5'd2, 32'd5, 1'b1})
      $display("FAIL first_accept: got v=%b rd=%0d d2=%h wb=%b expected v=1 rd=2 d2=5 wb=1",
               out_valid, rd, data2, wb_en);
    else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sub();
    in_valid = 1'b1; in_instr = 32'h40A28333; rs1_data = 32'd7; rs2_data = 32'd9; out_ready = 1'b1;
    #1;
    n_checks++;
    if ({rs1_addr, rs2_addr} !== {5'd5, 5'd10})
      $display("FAIL sub_addr: got rs1=%0d rs2=%0d expected 5 10", rs1_addr, rs2_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({out_valid, exec_fun, data1, data2, rd, wb_en} !== {1'b1, F_SUB, 32'd7, 32'd9, 5'd6, 1'b1})
      $display("FAIL sub_decode: got v=%b f=%0d d1=%h d2=%h rd=%0d wb=%b expected 1 1 7 9 6 1",
               out_valid, exec_fun, data1, data2, rd, wb_en);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL sub_drain: got out_valid=%b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_addi_x0();
    in_valid = 1'b1; in_instr = 32'hFFF00093; rs1_data = 32'h55; rs2_data = 32'h1234; out_ready = 1'b1;
    tick();
    n_checks++;
    if ({exec_fun, data1, data2, rd, wb_en} !== {F_ADD, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1})
      $display("FAIL addi_x0: got f=%0d d1=%h d2=%h rd=%0d wb=%b expected 0 0 ffffffff 1 1",
               exec_fun, data1, data2, rd, wb_en);
    else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall_and_back_to_back();
    logic [31:0] w;
    in_valid = 1'b1; in_instr = 32'h002081B3; rs1_data = 32'h11; rs2_data = 32'h22; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h00500113; rs1_data = $urandom; rs2_data = $urandom;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if ({out_valid, exec_fun, data1, data2, rd, wb_en} !== {1'b1, F_ADD, 32'h11, 32'h22, 5'd3, 1'b1})
        $display("FAIL stall_hold: cycle %0d got v=%b f=%0d d1=%h d2=%h rd=%0d expected 1 0 11 22 3",
                 i, out_valid, exec_fun, data1, data2, rd);
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = {12'(i * 7 + 1), 5'd0, 3'b000, 5'(i + 4), 7'b0010011};
      in_instr = w;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: beat %0d got %b expected 1", i, in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if ({out_valid, data2, rd} !== {1'b1, 32'(i * 7 + 1), 5'(i + 4)})
        $display("FAIL b2b_beat: beat %0d got v=%b d2=%h rd=%0d expected 1 %h %0d",
                 i, out_valid, data2, rd, 32'(i * 7 + 1), i + 4);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_jal();
    in_valid = 1'b1; in_instr = 32'hFF9FF0EF; in_pc = 32'd0; out_ready = 1'b1;
    tick();
    n_checks++;
    if ({exec_fun, data1, data2, br_type, br_target, rd, wb_en} !==
        {F_ADD, 32'd0, 32'd4, 3'd3, 32'hFFFF_FFF8, 5'd1, 1'b1})
      $display("FAIL jal_back: got f=%0d d1=%h d2=%h br=%0d tgt=%h rd=%0d wb=%b expected 0 0 4 3 fffffff8 1 1",
               exec_fun, data1, data2, br_type, br_target, rd, wb_en);
    else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_and_illegal();
    in_valid = 1'b1; in_instr = 32'h00500113; out_ready = 1'b1; flush = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_accept: got out_valid=%b expected 0", out_valid);
    else n_pass++;
    flush = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_held: got out_valid=%b expected 0", out_valid);
    else n_pass++;
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if ({out_valid, illegal, wb_en, mem_ren, mem_wen, br_type, exec_fun} !== {5'b11000, 3'd0, F_ADD})
      $display("FAIL illegal_7f: got v=%b ill=%b wb=%b ren=%b wen=%b br=%0d f=%0d expected 1 1 0 0 0 0 0",
               out_valid, illegal, wb_en, mem_ren, mem_wen, br_type, exec_fun);
    else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [31:0] w;
    bit acc;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++;
      if (out_valid !== (q.size() != 0))
        $display("FAIL rnd_valid: cycle %0d got %b expected %b", cyc, out_valid, q.size() != 0);
      else n_pass++;
      if (out_valid === 1'b1 && q.size() != 0) begin
        e = q[0];
        n_checks++;
        if ({exec_fun, wb_en, mem_ren, mem_wen, br_type, illegal} !== {e.fun, e.wb, e.ren, e.wen, e.br, e.ill})
          $display("FAIL rnd_ctrl: cycle %0d got %h expected %h", cyc,
                   {exec_fun, wb_en, mem_ren, mem_wen, br_type, illegal}, {e.fun, e.wb, e.ren, e.wen, e.br, e.ill});
        else n_pass++;
        if (!e.ill) begin
          n_checks++;
          if ({data1, data2, rs2_val} !== {e.d1, e.d2, e.r2v})
            $display("FAIL rnd_data: cycle %0d got %h %h %h expected %h %h %h",
                     cyc, data1, data2, rs2_val, e.d1, e.d2, e.r2v);
          else n_pass++;
        end
        if (e.wr) begin
          n_checks++;
          if (rd !== e.rd) $display("FAIL rnd_rd: cycle %0d got %0d expected %0d", cyc, rd, e.rd);
          else n_pass++;
        end
        if (e.br != 3'd0) begin
          n_checks++;
          if (br_target !== e.tgt)
            $display("FAIL rnd_target: cycle %0d got %h expected %h", cyc, br_target, e.tgt);
          else n_pass++;
        end
      end
      w = gen_instr();
      in_instr = w; in_pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      n_checks++;
      if (in_ready !== (q.size() == 0 || out_ready))
        $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", cyc, in_ready, q.size() == 0 || out_ready);
      else n_pass++;
      n_checks++;
      if ({rs1_addr, rs2_addr} !== {w[19:15], w[24:20]})
        $display("FAIL rnd_addr: cycle %0d got %0d %0d expected %0d %0d",
                 cyc, rs1_addr, rs2_addr, w[19:15], w[24:20]);
      else n_pass++;
      acc = in_valid && (q.size() == 0 || out_ready) && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) q.delete(0);
        if (acc) q.push_back(ref_decode(w, in_pc, rs1_data, rs2_data));
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; in_instr = 32'h002081B3; rs1_data = 32'h33; rs2_data = 32'h44; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midrst_setup: got out_valid=%b expected 1", out_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, wb_en, data1, data2, rd, in_ready} !== {2'b00, 64'd0, 5'd0, 1'b1})
      $display("FAIL midrst_async: got v=%b wb=%b d1=%h d2=%h rd=%0d rdy=%b expected 0 0 0 0 0 1",
               out_valid, wb_en, data1, data2, rd, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_discard: got out_valid=%b expected 0", out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_addi_x0();
    test_stall_and_back_to_back();
    test_jal();
    test_flush_and_illegal();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: in_instr/in_pc are valid.
REQ-005 SHALL have port in_ready, output, 1: the stage accepts input this cycle.
REQ-006 SHALL have port in_instr, input, 32: fetched instruction.
REQ-007 SHALL have port in_pc, input, WORD_LENGTH: PC of in_instr.
REQ-008 SHALL have port flush, input, 1: discard held and incoming instructions.
REQ-009 SHALL have ports rs1_addr and rs2_addr, output, 5 each: register-file read addresses, taken combinationally from in_instr[19:15] and in_instr[24:20].
REQ-010 SHALL have ports rs1_data and rs2_data, input, WORD_LENGTH each: register-file read data, valid in the same cycle.
REQ-011 SHALL have ports out_valid, output, 1 and out_ready, input, 1: downstream handshake.
REQ-012 SHALL have port exec_fun, output, EXEC_FUN: ALU operation code.
REQ-013 SHALL have ports data1 and data2, output, WORD_LENGTH each: ALU operands.
REQ-014 SHALL have port rs2_val, output, WORD_LENGTH: store data and branch compare operand.
REQ-015 SHALL have ports rd, output, 5 and wb_en, output, 1: writeback destination and enable.
REQ-016 SHALL have ports mem_ren, output, 1 and mem_wen, output, 1: load and store strobes.
REQ-017 SHALL have port br_type, output, 3: NONE=0, BEQ=1, BNE=2, JAL=3, JALR=4.
REQ-018 SHALL have ports br_target, output, WORD_LENGTH and illegal, output, 1: control-transfer target and unsupported-opcode flag.

Function
REQ-019 SHALL register all out_* and decode outputs in a single output stage, giving a latency of 1 cycle from accepted input to out_valid.
REQ-020 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-021 SHALL accept (capture) an instruction when in_valid && in_ready.
REQ-022 SHALL set out_valid on accept, clear it when out_ready is high with no new accept, and hold it otherwise.
REQ-023 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-024 SHALL force rs1_data/rs2_data to 0 when the corresponding address is 0, regardless of input value.
REQ-025 SHALL decode R-type (opcode 0110011) with funct3/funct7[5] to ALU_ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; data1=rs1, data2=rs2, wb_en=1.
REQ-026 SHALL decode I-ALU (0010011) to the same operations with data2 = sign-extended imm[11:0].
REQ-027 SHALL, for I-ALU shifts, use shamt = instr[24:20] and select SRA when instr[30]=1.
REQ-028 SHALL decode LUI as ALU_ADD with data1=0, data2={instr[31:12],12'b0}, wb_en=1.
REQ-029 SHALL decode AUIPC the same as LUI except data1=pc.
REQ-030 SHALL decode LOAD (0000011) as ALU_ADD rs1+imm_i with mem_ren=1 and wb_en=1.
REQ-031 SHALL decode STORE (0100011) as ALU_ADD rs1+imm_s with mem_wen=1, wb_en=0, rs2_val=rs2.
REQ-032 SHALL decode BRANCH (1100011) funct3 000/001 as ALU_ADD data1=rs1, data2=rs2, br_type BEQ/BNE, br_target=pc+imm_b, wb_en=0.
REQ-033 SHALL decode JAL as ALU_ADD data1=pc, data2=4, wb_en=1, br_type=JAL, br_target=pc+imm_j.
REQ-034 SHALL decode JALR as JAL except br_target=(rs1+imm_i)&~1 and br_type=JALR.
REQ-035 SHALL compute all address and target arithmetic modulo 2^WORD_LENGTH, with wrap-around and no overflow flag.
REQ-036 SHALL treat any other opcode or funct combination as illegal=1, with wb_en=mem_ren=mem_wen=0, br_type=NONE, exec_fun=ALU_ADD, and out_valid still asserted.
REQ-037 SHALL force wb_en=0 whenever rd=0.
REQ-038 SHALL, on flush, clear out_valid on the next edge and not capture any instruction in that cycle.
REQ-039 SHALL give flush priority over a simultaneous accept and over a held output.

Reset
REQ-040 SHALL, while rst_n=0, asynchronously force out_valid=0, wb_en=0, mem_ren=0, mem_wen=0, br_type=NONE, illegal=0, exec_fun=ALU_ADD, and data1, data2, rs2_val, br_target, rd to 0.
REQ-041 SHALL keep in_ready=1 during reset.
REQ-042 SHALL discard any instruction in flight when reset asserts mid-operation.
REQ-043 SHALL accept input on the first rising edge after rst_n deasserts.

Verification
REQ-044 SHALL verify: instr 0x40A28333 (sub x6,x5,x10) with rs1=7, rs2=9, out_ready=1 -> next cycle exec_fun=ALU_SUB, data1=7, data2=9, rd=6, wb_en=1.
REQ-045 SHALL verify: addi x1,x0,-1 (0xFFF00093) with rs1_data=0x55 -> data1=0, data2=0xFFFFFFFF.
REQ-046 SHALL verify: out_ready=0 for 3 cycles after accept -> in_ready=0 and outputs unchanged; out_ready=1 -> back-to-back accepts sustain 1 instruction/cycle.
REQ-047 SHALL verify: jal x1,-8 at pc 0x0 -> data1=0, data2=4, br_target=0xFFFFFFF8, br_type=JAL.
REQ-048 SHALL verify: flush coincident with in_valid -> out_valid=0 next cycle; opcode 0x7F -> illegal=1, no side-effect strobes.
REQ-049 SHALL verify: rst_n low mid-stall -> out_valid=0 immediately, without waiting for a clock edge.
